// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes (also used by ALU_Control) and FSM state encodings.
package alu_pkg;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_AND    = 4'b0010;
  localparam logic [3:0] ALU_OR     = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SLT    = 4'b0101;
  localparam logic [3:0] ALU_SLTU   = 4'b0110;
  localparam logic [3:0] ALU_SLL    = 4'b0111;
  localparam logic [3:0] ALU_SRL    = 4'b1000;
  localparam logic [3:0] ALU_SRA    = 4'b1001;
  localparam logic [3:0] ALU_PASS_B = 4'b1010;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU core for all single-cycle ops.
// With ALU_BARREL_SHIFT_EN defined it also performs shifts in one step.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = 5
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result
);

`ifdef ALU_BARREL_SHIFT_EN
  logic [SHAMT_WIDTH-1:0] shamt_s;
  assign shamt_s = b[SHAMT_WIDTH-1:0];
`endif

  // Operation decode; unknown codes yield zero.
  always_comb begin
    result = {DATA_WIDTH{1'b0}};
    case (op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      ALU_SLT:    result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:   result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      ALU_PASS_B: result = b;
`ifdef ALU_BARREL_SHIFT_EN
      ALU_SLL:    result = a << shamt_s;
      ALU_SRL:    result = a >> shamt_s;
      ALU_SRA:    result = $unsigned($signed(a) >>> shamt_s);
`endif
      default:    result = {DATA_WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU execution stage with start/busy/done handshake.
// Shifts are iterative (1 bit/cycle) unless ALU_BARREL_SHIFT_EN is defined.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] ALU_Result_o,
  output logic                  Zero_o
);

  localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic [DATA_WIDTH-1:0] result_r;
  logic [DATA_WIDTH-1:0] result_nxt_s;
  logic                  zero_r;
  logic                  done_r;
  logic                  busy_r;
  logic [DATA_WIDTH-1:0] comb_result_s;

  alu_comb #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_alu_comb (
    .op     (ALU_Operation_i),
    .a      (A_i),
    .b      (B_i),
    .result (comb_result_s)
  );

`ifndef ALU_BARREL_SHIFT_EN
  logic [DATA_WIDTH-1:0]  shift_r;
  logic [DATA_WIDTH-1:0]  shift_nxt_s;
  logic [DATA_WIDTH-1:0]  shift_step_s;
  logic [SHAMT_WIDTH-1:0] count_r;
  logic [SHAMT_WIDTH-1:0] count_nxt_s;
  logic [3:0]             op_r;
  logic [3:0]             op_nxt_s;
  logic [SHAMT_WIDTH-1:0] shamt_s;

  localparam logic [SHAMT_WIDTH-1:0] COUNT_ONE = {{(SHAMT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [DATA_WIDTH-1:0] shift_one(input logic [DATA_WIDTH-1:0] v,
                                                      input logic [3:0] op);
    case (op)
      ALU_SLL: return {v[DATA_WIDTH-2:0], 1'b0};
      ALU_SRL: return {1'b0, v[DATA_WIDTH-1:1]};
      ALU_SRA: return {v[DATA_WIDTH-1], v[DATA_WIDTH-1:1]};
      default: return v;
    endcase
  endfunction

  assign shamt_s      = B_i[SHAMT_WIDTH-1:0];
  assign shift_step_s = shift_one(shift_r, op_r);

  // Next-state logic for the iterative-shift FSM.
  always_comb begin
    state_nxt_s  = state_r;
    result_nxt_s = result_r;
    shift_nxt_s  = shift_r;
    count_nxt_s  = count_r;
    op_nxt_s     = op_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          if (is_shift_op(ALU_Operation_i) && (shamt_s != {SHAMT_WIDTH{1'b0}})) begin
            shift_nxt_s = A_i;
            count_nxt_s = shamt_s;
            op_nxt_s    = ALU_Operation_i;
            state_nxt_s = ST_SHIFT;
          end else begin
            result_nxt_s = is_shift_op(ALU_Operation_i) ? A_i : comb_result_s;
            state_nxt_s  = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shift_nxt_s = shift_step_s;
        count_nxt_s = count_r - COUNT_ONE;
        if (count_r == COUNT_ONE) begin
          result_nxt_s = shift_step_s;
          state_nxt_s  = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Shifter datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r <= {DATA_WIDTH{1'b0}};
      count_r <= {SHAMT_WIDTH{1'b0}};
      op_r    <= 4'b0000;
    end else begin
      shift_r <= shift_nxt_s;
      count_r <= count_nxt_s;
      op_r    <= op_nxt_s;
    end
  end
`else
  // Next-state logic when every op, shifts included, completes in one cycle.
  always_comb begin
    state_nxt_s  = state_r;
    result_nxt_s = result_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          result_nxt_s = comb_result_s;
          state_nxt_s  = ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end
`endif

  // State and registered outputs; Zero tracks the result in the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      result_r <= {DATA_WIDTH{1'b0}};
      zero_r   <= 1'b1;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      result_r <= result_nxt_s;
      zero_r   <= (result_nxt_s == {DATA_WIDTH{1'b0}});
      done_r   <= (state_nxt_s == ST_DONE);
      busy_r   <= (state_nxt_s != ST_IDLE);
    end
  end

  assign busy_o       = busy_r;
  assign done_o       = done_r;
  assign ALU_Result_o = result_r;
  assign Zero_o       = zero_r;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed cases plus randomized ops
// against a behavioural reference model (honours ALU_BARREL_SHIFT_EN).
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [3:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        zero_o;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model_result;

  alu_multicycle #(.DATA_WIDTH(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .ALU_Operation_i (op_i),
    .A_i             (a_i),
    .B_i             (b_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .ALU_Result_o    (result_o),
    .Zero_o          (zero_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int s;
    logic signed [31:0] sa;
    s  = int'(b[4:0]);
    sa = a;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a << s;
      4'd8:    return a >> s;
      4'd9:    return sa >>> s;
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    if ((op == 4'd7 || op == 4'd8 || op == 4'd9) && b[4:0] != 5'd0)
      return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  // Issue one op, scramble inputs while it runs, optionally poke start_i while busy.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke);
    logic [31:0] exp_res;
    int exp_lat;
    int lat;
    bit seen;
    exp_res = ref_alu(op, a, b);
    exp_lat = ref_latency(op, b);
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    start_i = 1'b0;
    a_i = $urandom; b_i = $urandom; op_i = 4'($urandom_range(0, 15));
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      if (done_o) begin
        seen = 1'b1;
        lat  = k;
      end else begin
        check("busy_during_shift", {31'd0, busy_o}, 32'd1);
        check("result_held", result_o, model_result);
        start_i = poke ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
      end
    end
    check("latency", lat, exp_lat);
    check("result", result_o, exp_res);
    check("zero", {31'd0, zero_o}, {31'd0, (exp_res == 32'd0)});
    check("busy_in_done", {31'd0, busy_o}, 32'd1);
    model_result = exp_res;
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done_o}, 32'd0);
    check("idle_after_done", {31'd0, busy_o}, 32'd0);
    check("result_kept", result_o, model_result);
  endtask

  initial begin
    bit any_done;
    reset = 1'b1; start_i = 1'b0; op_i = 4'd0; a_i = 32'd0; b_i = 32'd0;
    model_result = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_zero", {31'd0, zero_o}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(4'd0, 32'h0000_0005, 32'h0000_0003, 1'b0);
    run_op(4'd1, 32'h1234_5678, 32'h1234_5678, 1'b0);
    run_op(4'd5, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(4'd6, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(4'd9, 32'h8000_0000, 32'h0000_0004, 1'b1);
    run_op(4'd7, 32'h0000_0001, 32'hFFFF_FFE0, 1'b0);
    run_op(4'd8, 32'hF000_000F, 32'h0000_001F, 1'b1);
    run_op(4'd10, 32'h0, 32'hABCD_E000, 1'b0);
    run_op(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // Reset partway through a long shift.
    @(negedge clk);
    start_i = 1'b1; op_i = 4'd7; a_i = 32'h0000_0001; b_i = 32'd31;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_done", {31'd0, done_o}, 32'd0);
    check("midrst_result", result_o, 32'd0);
    check("midrst_zero", {31'd0, zero_o}, 32'd1);
    model_result = 32'd0;
    any_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done_o) any_done = 1'b1;
    end
    check("midrst_no_done", {31'd0, any_done}, 32'd0);
    run_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
